data_island_scheduler: RTL
==========================

# data_island_scheduler

Sequences HDMI data-island periods inside each horizontal blanking interval, in the pixel clock domain, ahead of the packet picker and TMDS encoders. Per line it sizes the island from the upcoming blanking length and emits the control/preamble/guard/island period flags. It also emits the `packet_enable` strobe and the `packet_pixel_counter` that drive packet selection and per-packet serialization.

## Interface
Parameters:
- `MAX_PACKETS`, 18: upper bound on packets per island, 1..18.

Ports:
- `clk_pixel`  in  1  pixel clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `display_enable`  in  1  high during the video data period.
- `blank_pixels`  in  12  length in pixels of the blanking interval that starts when `display_enable` falls; sampled on that cycle.
- `data_island_preamble`  out  1  data-island preamble (CTL pattern) period.
- `data_island_guard`  out  1  leading or trailing data-island guard band.
- `data_island_period`  out  1  packet pixels being transmitted.
- `packet_enable`  out  1  one-cycle strobe; the packet picker selects the next packet on it.
- `packet_pixel_counter`  out  5  pixel index 0..31 within the current packet.
- `schedule_error`  out  1  sticky error; set when an island is aborted.
- `packets_in_frame`  out  16  packets sent since the last `frame_start` (see Configuration).
- `frame_start`  in  1  one-cycle pulse at frame start; used only by the statistics feature.

## Operation
- Capacity: `N = min(MAX_PACKETS, (blank_pixels - 38) >> 5)`. `N = 0` when `blank_pixels < 70`.
- The 38-pixel reserve breaks down as:
  - 4-pixel control gap.
  - 8-pixel preamble.
  - 2 + 2 guard pixels.
  - 12-pixel minimum trailing control period.
  - 10 pixels reserved for the video preamble and guard.
- Compute the capacity in 13-bit unsigned arithmetic, so it cannot underflow.
- States: IDLE, GAP, PREAMBLE, LEAD_GUARD, PACKET, TRAIL_GUARD, DONE.
- State transitions:
  - IDLE → GAP on the falling edge of `display_enable`, when `N > 0`.
  - IDLE → DONE on that falling edge, when `N = 0`.
  - GAP lasts 4 cycles, then PREAMBLE.
  - PREAMBLE lasts 8 cycles, then LEAD_GUARD.
  - LEAD_GUARD lasts 2 cycles, then PACKET.
  - PACKET lasts 32·N cycles, then TRAIL_GUARD.
  - TRAIL_GUARD lasts 2 cycles, then DONE.
  - DONE → IDLE when `display_enable` rises.
- Counters:
  - A 5-bit pixel counter wraps 31→0.
  - A 5-bit packet counter counts the packets sent.
  - PACKET exits when the pixel counter is 31 and the packet counter equals N-1.
- Abort: if `display_enable` rises in any state other than IDLE or DONE, go to IDLE next cycle.
  - All period flags deassert.
  - `schedule_error` sets and stays set until reset.
- `packet_pixel_counter` is 0 outside PACKET.

## Timing
- Reset value of every output is 0; the state resets to IDLE.
- Let t be the first cycle with `display_enable = 0`:
  - GAP: t..t+3.
  - `data_island_preamble`: t+4..t+11.
  - `data_island_guard`: t+12..t+13 and t+14+32N..t+15+32N.
  - Packet k: t+14+32k..t+45+32k, with `data_island_period` = 1 and `packet_pixel_counter` = 0..31.
- `packet_enable` pulses:
  - at t+13, the last leading-guard cycle;
  - on each cycle where `packet_pixel_counter` = 31 for packets 0..N-2.
- The packet picker registers on `packet_enable`, so its selection is valid from the packet's first pixel.
- All outputs are registered. Flags change on the same edge as the state.
- A `display_enable` fall while not in IDLE, which can only follow an abort, is ignored until the state returns to IDLE.

## Configuration
- `DI_FRAME_STATS_EN` defined:
  - `packets_in_frame` counts PACKET-state packet starts.
  - The counter saturates at 0xFFFF.
  - It clears on `frame_start`; on a simultaneous start and clear, the clear wins and the result is 0.
- Undefined: `packets_in_frame` is tied to 0, `frame_start` is ignored, and no counter logic is generated.

## Structure
- Shared package `hdmi_di_pkg` holds:
  - the state enum `di_state_t`;
  - the constants `DI_CTL_GAP=4`, `DI_PREAMBLE_LEN=8`, `DI_GUARD_LEN=2`, `DI_PACKET_LEN=32`, `DI_RESERVE=38`.
- One sub-module, `di_capacity_calc`: combinational computation of `blank_pixels` → N, including the clamp.

## Test plan
- `blank_pixels=138`, `MAX_PACKETS=18` → N=3:
  - preamble at t+4..t+11;
  - `data_island_period` for 96 cycles starting at t+14;
  - `packet_enable` pulses at t+13, t+45, t+77;
  - trailing guard at t+110..t+111.
- `blank_pixels=70` → N=1: a single `packet_enable` at t+13, and the island ends at t+47.
- `blank_pixels=69` → N=0: no preamble, guard or `packet_enable`; the state goes to DONE, then IDLE on the `display_enable` rise.
- `blank_pixels=1000`, `MAX_PACKETS=18` → raw capacity 30, clamped to 18: `data_island_period` lasts exactly 576 cycles.
- `display_enable` rises at t+20 with N=3 → all flags are 0 at t+21 and `schedule_error`=1. A following line with `blank_pixels=70` schedules normally while `schedule_error` stays 1.
- `reset_n` asserted mid-PACKET → all outputs are 0 immediately (asynchronous). After release, no activity until the next `display_enable` fall.
- With `DI_FRAME_STATS_EN` defined: two lines of N=3 → `packets_in_frame`=6. `frame_start` then clears it to 0.

Source files
------------

// File: rtl/hdmi_di_pkg.sv
// Shared types and timing constants for the HDMI data-island scheduler.
package hdmi_di_pkg;

  typedef enum logic [2:0] {
    DI_IDLE,
    DI_GAP,
    DI_PREAMBLE,
    DI_LEAD_GUARD,
    DI_PACKET,
    DI_TRAIL_GUARD,
    DI_DONE
  } di_state_t;

  localparam int unsigned DI_CTL_GAP      = 4;
  localparam int unsigned DI_PREAMBLE_LEN = 8;
  localparam int unsigned DI_GUARD_LEN    = 2;
  localparam int unsigned DI_PACKET_LEN   = 32;
  localparam int unsigned DI_RESERVE      = 38;

  localparam int unsigned DI_BLANK_W   = 12;
  localparam int unsigned DI_CALC_W    = 13;
  localparam int unsigned DI_CNT_W     = 5;
  localparam int unsigned DI_STATS_W   = 16;
  localparam int unsigned DI_MIN_BLANK = DI_RESERVE + DI_PACKET_LEN;

endpackage

// File: rtl/di_capacity_calc.sv
// Packets that fit in the upcoming blanking interval, clamped to MAX_PACKETS.
module di_capacity_calc
  import hdmi_di_pkg::*;
#(
  parameter int unsigned MAX_PACKETS = 18
) (
  input  logic [DI_BLANK_W-1:0] blank_pixels,
  output logic [DI_CNT_W-1:0]   capacity
);

  logic [DI_CALC_W-1:0] excess;
  logic [DI_CALC_W-1:0] raw;

  always_comb begin
    excess   = '0;
    raw      = '0;
    capacity = '0;
    if (blank_pixels >= DI_BLANK_W'(DI_MIN_BLANK)) begin
      excess = DI_CALC_W'(blank_pixels) - DI_CALC_W'(DI_RESERVE);
      raw    = excess >> $clog2(DI_PACKET_LEN);
      if (raw > DI_CALC_W'(MAX_PACKETS)) begin
        capacity = DI_CNT_W'(MAX_PACKETS);
      end else begin
        capacity = DI_CNT_W'(raw);
      end
    end
  end

endmodule

// File: rtl/data_island_scheduler.sv
// Schedules one HDMI data island per horizontal blanking interval.
// Optional per-frame packet statistics are enabled with DI_FRAME_STATS_EN.
module data_island_scheduler
  import hdmi_di_pkg::*;
#(
  parameter int unsigned MAX_PACKETS = 18
) (
  input  logic                  clk_pixel,
  input  logic                  reset_n,
  input  logic                  display_enable,
  input  logic [DI_BLANK_W-1:0] blank_pixels,
  output logic                  data_island_preamble,
  output logic                  data_island_guard,
  output logic                  data_island_period,
  output logic                  packet_enable,
  output logic [DI_CNT_W-1:0]   packet_pixel_counter,
  output logic                  schedule_error,
  output logic [DI_STATS_W-1:0] packets_in_frame,
  input  logic                  frame_start
);

  di_state_t           state;
  logic                de_q;
  logic [DI_CNT_W-1:0] phase_cnt;
  logic [DI_CNT_W-1:0] packet_cnt;
  logic [DI_CNT_W-1:0] island_len;
  logic [DI_CNT_W-1:0] capacity;
  logic                de_fall;
  logic                abort;
  logic                last_packet;

  di_capacity_calc #(.MAX_PACKETS(MAX_PACKETS)) u_capacity (
    .blank_pixels (blank_pixels),
    .capacity     (capacity)
  );

  assign de_fall     = de_q && !display_enable;
  assign abort       = display_enable && (state != DI_IDLE) && (state != DI_DONE);
  assign last_packet = (packet_cnt == island_len - DI_CNT_W'(1));

  // Island sequencer; flags are registered alongside the state they belong to.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state                <= DI_IDLE;
      de_q                 <= 1'b0;
      phase_cnt            <= '0;
      packet_cnt           <= '0;
      island_len           <= '0;
      data_island_preamble <= 1'b0;
      data_island_guard    <= 1'b0;
      data_island_period   <= 1'b0;
      packet_enable        <= 1'b0;
      packet_pixel_counter <= '0;
      schedule_error       <= 1'b0;
    end else begin
      de_q          <= display_enable;
      packet_enable <= 1'b0;
      if (abort) begin
        state                <= DI_IDLE;
        phase_cnt            <= '0;
        packet_cnt           <= '0;
        data_island_preamble <= 1'b0;
        data_island_guard    <= 1'b0;
        data_island_period   <= 1'b0;
        packet_pixel_counter <= '0;
        schedule_error       <= 1'b1;
      end else begin
        unique case (state)
          DI_IDLE: begin
            if (de_fall) begin
              // The fall-detect cycle is already the first control-gap pixel.
              phase_cnt  <= DI_CNT_W'(1);
              island_len <= capacity;
              state      <= (capacity != '0) ? DI_GAP : DI_DONE;
            end
          end
          DI_GAP: begin
            if (phase_cnt == DI_CNT_W'(DI_CTL_GAP - 1)) begin
              state                <= DI_PREAMBLE;
              phase_cnt            <= '0;
              data_island_preamble <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt + DI_CNT_W'(1);
            end
          end
          DI_PREAMBLE: begin
            if (phase_cnt == DI_CNT_W'(DI_PREAMBLE_LEN - 1)) begin
              state                <= DI_LEAD_GUARD;
              phase_cnt            <= '0;
              data_island_preamble <= 1'b0;
              data_island_guard    <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt + DI_CNT_W'(1);
            end
          end
          DI_LEAD_GUARD: begin
            if (phase_cnt == DI_CNT_W'(DI_GUARD_LEN - 1)) begin
              state                <= DI_PACKET;
              phase_cnt            <= '0;
              packet_cnt           <= '0;
              packet_pixel_counter <= '0;
              data_island_guard    <= 1'b0;
              data_island_period   <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt + DI_CNT_W'(1);
              // Strobe lands on the last guard pixel so the picker is ready for pixel 0.
              if (phase_cnt == DI_CNT_W'(DI_GUARD_LEN - 2)) packet_enable <= 1'b1;
            end
          end
          DI_PACKET: begin
            if (packet_pixel_counter == DI_CNT_W'(DI_PACKET_LEN - 1)) begin
              packet_pixel_counter <= '0;
              if (last_packet) begin
                state              <= DI_TRAIL_GUARD;
                phase_cnt          <= '0;
                data_island_period <= 1'b0;
                data_island_guard  <= 1'b1;
              end else begin
                packet_cnt <= packet_cnt + DI_CNT_W'(1);
              end
            end else begin
              packet_pixel_counter <= packet_pixel_counter + DI_CNT_W'(1);
              if (packet_pixel_counter == DI_CNT_W'(DI_PACKET_LEN - 2) && !last_packet) begin
                packet_enable <= 1'b1;
              end
            end
          end
          DI_TRAIL_GUARD: begin
            if (phase_cnt == DI_CNT_W'(DI_GUARD_LEN - 1)) begin
              state             <= DI_DONE;
              phase_cnt         <= '0;
              data_island_guard <= 1'b0;
            end else begin
              phase_cnt <= phase_cnt + DI_CNT_W'(1);
            end
          end
          DI_DONE: begin
            if (display_enable) state <= DI_IDLE;
          end
          default: state <= DI_IDLE;
        endcase
      end
    end
  end

`ifdef DI_FRAME_STATS_EN
  logic packet_start;

  assign packet_start = data_island_period && (packet_pixel_counter == '0);

  // Saturating per-frame packet count; frame_start has priority over a start.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      packets_in_frame <= '0;
    end else if (frame_start) begin
      packets_in_frame <= '0;
    end else if (packet_start && (packets_in_frame != '1)) begin
      packets_in_frame <= packets_in_frame + DI_STATS_W'(1);
    end
  end
`else
  logic unused_frame_start;

  assign unused_frame_start = frame_start;
  assign packets_in_frame   = '0;
`endif

endmodule
